// File: rtl/uart_host_pkg.sv
// Shared types and UART register map for the host-side bus sequencer.
package uart_host_pkg;

  typedef enum logic [3:0] {
    C_LCRD,
    C_DLL,
    C_DLM,
    C_LCR,
    C_FCR,
    POLL,
    LSR_W,
    RX_RD,
    RX_W,
    TX_WR
  } host_state_t;

  typedef enum logic {
    GR_RX = 1'b0,
    GR_TX = 1'b1
  } grant_t;

  localparam logic [2:0] ADDR_THR = 3'd0;
  localparam logic [2:0] ADDR_DLM = 3'd1;
  localparam logic [2:0] ADDR_FCR = 3'd2;
  localparam logic [2:0] ADDR_LCR = 3'd3;
  localparam logic [2:0] ADDR_LSR = 3'd5;

  localparam int LSR_DR   = 0;
  localparam int LSR_THRE = 5;

  localparam logic [7:0] LCR_DLAB = 8'h80;

endpackage

// File: rtl/uart_host_seq_if.sv
// Streaming clients plus UART register bus as seen by the host sequencer.
interface uart_host_seq_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       cfg_done;
  logic       u_wr;
  logic       u_rd;
  logic [2:0] u_addr;
  logic [7:0] u_din;
  logic [7:0] u_dout;

  modport master (
    input  tx_valid, tx_data, rx_ready, u_dout,
    output tx_ready, rx_valid, rx_data, cfg_done, u_wr, u_rd, u_addr, u_din
  );

  modport slave (
    output tx_valid, tx_data, rx_ready, u_dout,
    input  tx_ready, rx_valid, rx_data, cfg_done, u_wr, u_rd, u_addr, u_din
  );
endinterface

// File: rtl/uart_host_rxbuf.sv
// One-entry receive output register with valid/ready handshake.
module uart_host_rxbuf (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       rx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data
);

  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;

  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    // The sequencer only loads while the buffer is empty, so load wins safely.
    if (load) begin
      rx_valid_d = 1'b1;
      rx_data_d  = load_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
    end else begin
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

endmodule

// File: rtl/uart_host_seq.sv
// Host sequencer: configures the UART, then polls LSR and round-robins TX/RX onto the register bus.
module uart_host_seq #(
  parameter logic [15:0] DIVISOR = 16'd54,
  parameter logic [7:0]  LCR_VAL = 8'h03,
  parameter logic [7:0]  FCR_VAL = 8'h01
) (
  input logic              clk,
  input logic              rst,
  uart_host_seq_if.master  bus
);
  import uart_host_pkg::*;

  host_state_t state_q, state_d;
  grant_t      last_q, last_d;

  logic       u_wr_q, u_wr_d;
  logic       u_rd_q, u_rd_d;
  logic [2:0] u_addr_q, u_addr_d;
  logic [7:0] u_din_q, u_din_d;
  logic       tx_ready_q, tx_ready_d;
  logic       cfg_done_q, cfg_done_d;

  logic       rx_ok, tx_ok;
  logic       rx_load;
  logic       rx_valid;
  logic [7:0] rx_data;

  always_comb begin
    rx_ok   = bus.u_dout[LSR_DR] && !rx_valid;
    tx_ok   = bus.u_dout[LSR_THRE] && bus.tx_valid;
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      // Straight out of reset the LCR write has not been issued yet; stay one cycle to issue it.
      C_LCRD: state_d = u_wr_q ? C_DLL : C_LCRD;
      C_DLL:  state_d = C_DLM;
      C_DLM:  state_d = C_LCR;
      C_LCR:  state_d = C_FCR;
      C_FCR:  state_d = POLL;
      POLL:   state_d = LSR_W;
      LSR_W: begin
        if (rx_ok && tx_ok) state_d = (last_q == GR_TX) ? RX_RD : TX_WR;
        else if (tx_ok)     state_d = TX_WR;
        else if (rx_ok)     state_d = RX_RD;
        else                state_d = POLL;
      end
      RX_RD:  state_d = RX_W;
      RX_W: begin
        state_d = POLL;
        last_d  = GR_RX;
      end
      TX_WR: begin
        state_d = POLL;
        last_d  = GR_TX;
      end
      default: state_d = C_LCRD;
    endcase
  end

  // Bus outputs are decoded from the next state so they are flops yet line up with the state they belong to.
  always_comb begin
    u_wr_d   = 1'b0;
    u_rd_d   = 1'b0;
    u_addr_d = 3'd0;
    u_din_d  = 8'h00;
    unique case (state_d)
      C_LCRD: begin u_wr_d = 1'b1; u_addr_d = ADDR_LCR; u_din_d = LCR_VAL | LCR_DLAB;  end
      C_DLL:  begin u_wr_d = 1'b1; u_addr_d = ADDR_THR; u_din_d = DIVISOR[7:0];        end
      C_DLM:  begin u_wr_d = 1'b1; u_addr_d = ADDR_DLM; u_din_d = DIVISOR[15:8];       end
      C_LCR:  begin u_wr_d = 1'b1; u_addr_d = ADDR_LCR; u_din_d = LCR_VAL & ~LCR_DLAB; end
      C_FCR:  begin u_wr_d = 1'b1; u_addr_d = ADDR_FCR; u_din_d = FCR_VAL;             end
      POLL:   begin u_rd_d = 1'b1; u_addr_d = ADDR_LSR;                                end
      RX_RD:  begin u_rd_d = 1'b1; u_addr_d = ADDR_THR;                                end
      TX_WR:  begin u_wr_d = 1'b1; u_addr_d = ADDR_THR; u_din_d = bus.tx_data;         end
      default: ;
    endcase
    tx_ready_d = (state_d == TX_WR);
    cfg_done_d = cfg_done_q || (state_d == POLL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= C_LCRD;
      last_q     <= GR_RX;
      u_wr_q     <= 1'b0;
      u_rd_q     <= 1'b0;
      u_addr_q   <= 3'd0;
      u_din_q    <= 8'h00;
      tx_ready_q <= 1'b0;
      cfg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      u_wr_q     <= u_wr_d;
      u_rd_q     <= u_rd_d;
      u_addr_q   <= u_addr_d;
      u_din_q    <= u_din_d;
      tx_ready_q <= tx_ready_d;
      cfg_done_q <= cfg_done_d;
    end
  end

  assign rx_load = (state_q == RX_W);

  uart_host_rxbuf u_rxbuf (
    .clk       (clk),
    .rst       (rst),
    .load      (rx_load),
    .load_data (bus.u_dout),
    .rx_ready  (bus.rx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data)
  );

  assign bus.u_wr     = u_wr_q;
  assign bus.u_rd     = u_rd_q;
  assign bus.u_addr   = u_addr_q;
  assign bus.u_din    = u_din_q;
  assign bus.tx_ready = tx_ready_q;
  assign bus.cfg_done = cfg_done_q;
  assign bus.rx_valid = rx_valid;
  assign bus.rx_data  = rx_data;

endmodule

// File: tb/tb_uart_host_seq.sv
// Scoreboard bench for uart_host_seq: a UART register model answers reads; a monitor checks bus and RX traffic.
module tb_uart_host_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_host_seq_if bus();

  uart_host_seq #(.DIVISOR(16'd54), .LCR_VAL(8'h03), .FCR_VAL(8'h01)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    int         cyc;
    bit         wr;
    logic [2:0] addr;
    logic [7:0] data;
    bit         txr;
  } bus_t;

  bus_t       exp_q[$];
  logic [7:0] exp_rx[$];
  bus_t       mon_e;
  logic [7:0] mon_rx;

  int         cyc;
  int         n_cmp = 0;
  int         n_err = 0;
  int         tx_pulses = 0;
  int         tx_base;
  bit         mon_en = 1'b0;
  logic [7:0] lsr_val, rbr_val;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // UART register model: read data appears in the cycle after u_rd.
  always @(posedge clk or negedge rst) begin
    if (!rst) bus.u_dout <= 8'h00;
    else if (bus.u_rd)
      bus.u_dout <= (bus.u_addr == 3'd5) ? lsr_val : ((bus.u_addr == 3'd0) ? rbr_val : 8'h00);
  end

  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if (bus.u_wr && bus.u_rd) begin
        n_err++;
        $display("FAIL strobe_excl cyc=%0d wr=%0b rd=%0b want not both", cyc, bus.u_wr, bus.u_rd);
      end
      if (bus.tx_ready) tx_pulses++;
      if (bus.u_wr || bus.u_rd) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL bus_unexpected cyc=%0d wr=%0b rd=%0b addr=%0d din=%h want no access",
                   cyc, bus.u_wr, bus.u_rd, bus.u_addr, bus.u_din);
        end else begin
          mon_e = exp_q.pop_front();
          if (cyc != mon_e.cyc || bus.u_wr != mon_e.wr || bus.u_rd != !mon_e.wr ||
              bus.u_addr != mon_e.addr || (mon_e.wr && bus.u_din != mon_e.data) ||
              bus.tx_ready != mon_e.txr) begin
            n_err++;
            $display("FAIL bus_txn got cyc=%0d wr=%0b rd=%0b addr=%0d din=%h txr=%0b want cyc=%0d wr=%0b addr=%0d din=%h txr=%0b",
                     cyc, bus.u_wr, bus.u_rd, bus.u_addr, bus.u_din, bus.tx_ready,
                     mon_e.cyc, mon_e.wr, mon_e.addr, mon_e.data, mon_e.txr);
          end
        end
      end
      if (bus.rx_valid && bus.rx_ready) begin
        n_cmp++;
        if (exp_rx.size() == 0) begin
          n_err++;
          $display("FAIL rx_unexpected cyc=%0d got=%h want none", cyc, bus.rx_data);
        end else begin
          mon_rx = exp_rx.pop_front();
          if (bus.rx_data !== mon_rx) begin
            n_err++;
            $display("FAIL rx_byte cyc=%0d got=%h want=%h", cyc, bus.rx_data, mon_rx);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 1000) begin
        $display("FAIL wait_cyc timeout at=%0d want=%0d", cyc, n);
        $fatal(1, "cycle budget exceeded");
      end
    end
  endtask

  task automatic push_w(input int c, input logic [2:0] a, input logic [7:0] d, input bit t);
    bus_t e;
    e.cyc = c; e.wr = 1'b1; e.addr = a; e.data = d; e.txr = t;
    exp_q.push_back(e);
  endtask

  task automatic push_r(input int c, input logic [2:0] a);
    bus_t e;
    e.cyc = c; e.wr = 1'b0; e.addr = a; e.data = 8'h00; e.txr = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic start_phase(input logic [7:0] lsr, input logic txv, input logic [7:0] txd,
                             input logic [7:0] rbr, input logic rxr);
    mon_en = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    lsr_val = lsr; rbr_val = rbr;
    bus.tx_valid = txv; bus.tx_data = txd; bus.rx_ready = rxr;
    exp_q.delete(); exp_rx.delete();
    tx_base = tx_pulses;
    push_w(1, 3'd3, 8'h83, 1'b0);
    push_w(2, 3'd0, 8'h36, 1'b0);
    push_w(3, 3'd1, 8'h00, 1'b0);
    push_w(4, 3'd3, 8'h03, 1'b0);
    push_w(5, 3'd2, 8'h01, 1'b0);
    push_r(6, 3'd5);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic end_phase(input int h, input int txp);
    wait_cyc(h);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("bus_missing", exp_q.size(), 0);
    chk("rx_missing", exp_rx.size(), 0);
    chk("tx_pulses", tx_pulses - tx_base, txp);
  endtask

  initial begin
    rst = 1'b0;
    bus.tx_valid = 1'b0; bus.tx_data = 8'h00; bus.rx_ready = 1'b0;
    lsr_val = 8'h00; rbr_val = 8'h00;
    #23;
    chk("reset_outputs", {bus.u_wr, bus.u_rd, bus.u_addr, bus.u_din, bus.tx_ready,
                          bus.rx_valid, bus.cfg_done, bus.rx_data}, 32'h0);

    // Config sequence, then idle LSR polling every 2 cycles.
    start_phase(8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    push_r(8, 3'd5); push_r(10, 3'd5); push_r(12, 3'd5);
    wait_cyc(5);
    chk("cfg_done_c5", bus.cfg_done, 0);
    wait_cyc(6);
    chk("cfg_done_c6", bus.cfg_done, 1);
    end_phase(13, 0);

    // Single TX byte when THRE is set.
    start_phase(8'h20, 1'b1, 8'hA5, 8'h00, 1'b1);
    push_w(8, 3'd0, 8'hA5, 1'b1);
    push_r(9, 3'd5); push_r(11, 3'd5); push_r(13, 3'd5);
    wait_cyc(9);
    bus.tx_valid = 1'b0;
    end_phase(13, 1);

    // Both eligible: grants alternate TX, RX, TX, RX, TX.
    start_phase(8'h21, 1'b1, 8'h3C, 8'h5C, 1'b1);
    push_w(8, 3'd0, 8'h3C, 1'b1); push_r(9, 3'd5); push_r(11, 3'd0); push_r(13, 3'd5);
    push_w(15, 3'd0, 8'h3C, 1'b1); push_r(16, 3'd5); push_r(18, 3'd0); push_r(20, 3'd5);
    push_w(22, 3'd0, 8'h3C, 1'b1);
    exp_rx.push_back(8'h5C); exp_rx.push_back(8'h77);
    wait_cyc(13);
    chk("rx_first_data", {bus.rx_valid, bus.rx_data}, {1'b1, 8'h5C});
    wait_cyc(14);
    rbr_val = 8'h77;
    end_phase(22, 3);

    // Consumer stalls: no RBR reads while rx_valid, TX keeps going.
    start_phase(8'h21, 1'b1, 8'h42, 8'h11, 1'b0);
    push_w(8, 3'd0, 8'h42, 1'b1); push_r(9, 3'd5); push_r(11, 3'd0); push_r(13, 3'd5);
    push_w(15, 3'd0, 8'h42, 1'b1); push_r(16, 3'd5); push_w(18, 3'd0, 8'h42, 1'b1);
    push_r(19, 3'd5); push_w(21, 3'd0, 8'h42, 1'b1); push_r(22, 3'd5);
    push_r(24, 3'd0); push_r(26, 3'd5);
    exp_rx.push_back(8'h11); exp_rx.push_back(8'h99);
    wait_cyc(14);
    rbr_val = 8'h99;
    chk("rx_hold_c14", {bus.rx_valid, bus.rx_data}, {1'b1, 8'h11});
    wait_cyc(21);
    chk("rx_hold_c21", {bus.rx_valid, bus.rx_data}, {1'b1, 8'h11});
    wait_cyc(22);
    bus.rx_ready = 1'b1;
    end_phase(26, 4);

    // Reset asserted during TX_WR, then configuration restarts.
    start_phase(8'h20, 1'b1, 8'hA5, 8'h00, 1'b1);
    wait_cyc(8);
    chk("tx_wr_before_reset", {bus.tx_ready, bus.u_wr, bus.u_din}, {1'b1, 1'b1, 8'hA5});
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", {bus.u_wr, bus.u_rd, bus.u_addr, bus.u_din, bus.tx_ready,
                                bus.rx_valid, bus.cfg_done, bus.rx_data}, 32'h0);
    start_phase(8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    push_r(8, 3'd5);
    end_phase(9, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached want finish earlier");
    $fatal(1, "global timeout");
  end

endmodule
